// File: rtl/drum_trigger_gen.sv
// Per-instrument 8-step hit patterns turned into trigger pulses and fixed-length gates
// on each sequencer beat entry; the beat index is resynchronised from the slow clock domain.
module drum_trigger_gen #(
    parameter int unsigned GATE_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pattern_in,
    input  logic       ld_ins1,
    input  logic       ld_ins2,
    input  logic       ld_ins3,
    input  logic       ld_ins4,
    input  logic       play,
    input  logic [3:0] timing,
    output logic [3:0] trig,
    output logic [3:0] gate,
    output logic [3:0] hits,
    output logic [7:0] step_led
);

    localparam int unsigned CW = $clog2(GATE_CYCLES + 1);
    localparam logic [CW-1:0] GateLoad = CW'(GATE_CYCLES);

    logic [3:0]         ld;
    logic [3:0][7:0]    pat_q, pat_d;
    logic [3:0]         t_s1_q, t_s2_q, t_s3_q;
    logic [3:0]         t_stab_q, t_stab_d;
    logic [3:0]         step_q, step_d;
    logic [3:0]         trig_q, trig_d;
    logic [3:0][CW-1:0] cnt_q, cnt_d;

    logic       update;
    logic       new_valid;
    logic [2:0] new_idx;
    logic       cur_valid;
    logic [2:0] cur_idx;

    assign ld = {ld_ins4, ld_ins3, ld_ins2, ld_ins1};

    // A new beat index is accepted only once it has held for two consecutive cycles.
    assign update    = (t_s2_q == t_s3_q) && (t_s2_q != t_stab_q);
    assign new_valid = (t_s2_q != 4'd0) && (t_s2_q <= 4'd8);
    assign new_idx   = 3'(t_s2_q - 4'd1);
    assign cur_valid = (step_q != 4'd0) && (step_q <= 4'd8);
    assign cur_idx   = 3'(step_q - 4'd1);

    always_comb begin
        pat_d = pat_q;
        for (int i = 0; i < 4; i++) begin
            if (ld[i]) begin
                pat_d[i] = pattern_in;
            end
        end
    end

    assign t_stab_d = update ? t_s2_q : t_stab_q;

    always_comb begin
        step_d = step_q;
        trig_d = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : cnt_q[i];
        end
        if (!play) begin
            step_d = 4'd0;
            cnt_d  = '0;
        end else if (update) begin
            if (new_valid) begin
                step_d = t_s2_q;
                for (int i = 0; i < 4; i++) begin
                    if (pat_q[i][new_idx]) begin
                        trig_d[i] = 1'b1;
                        cnt_d[i]  = GateLoad;
                    end
                end
            end else begin
                step_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q    <= '0;
            t_s1_q   <= 4'd0;
            t_s2_q   <= 4'd0;
            t_s3_q   <= 4'd0;
            t_stab_q <= 4'd0;
            step_q   <= 4'd0;
            trig_q   <= 4'd0;
            cnt_q    <= '0;
        end else begin
            pat_q    <= pat_d;
            t_s1_q   <= timing;
            t_s2_q   <= t_s1_q;
            t_s3_q   <= t_s2_q;
            t_stab_q <= t_stab_d;
            step_q   <= step_d;
            trig_q   <= trig_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        trig     = trig_q;
        gate     = '0;
        hits     = '0;
        step_led = '0;
        for (int i = 0; i < 4; i++) begin
            gate[i] = (cnt_q[i] != '0);
            hits[i] = cur_valid && pat_q[i][cur_idx];
        end
        if (cur_valid) begin
            step_led = 8'd1 << cur_idx;
        end
    end

endmodule

// File: tb/tb_drum_trigger_gen.sv
// Scoreboard bench: each accepted beat pushes the expected trig/hits/step_led entry,
// which the negedge monitor pops on the cycle the DUT must show it.
module tb_drum_trigger_gen;

    localparam int unsigned G = 4;

    typedef struct {
        int         cyc;
        logic [3:0] trig;
        logic [7:0] led;
        logic [3:0] hits;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] pattern_in;
    logic [3:0] ld;
    logic       play;
    logic [3:0] timing;
    logic [3:0] trig;
    logic [3:0] gate;
    logic [3:0] hits;
    logic [7:0] step_led;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         play_seen = 0;
    exp_t       sb[$];
    logic [7:0] tb_pat[4];
    logic [3:0] last_t;
    logic [7:0] exp_led;
    int         left[4];

    drum_trigger_gen #(
        .GATE_CYCLES(G)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pattern_in(pattern_in),
        .ld_ins1   (ld[0]),
        .ld_ins2   (ld[1]),
        .ld_ins3   (ld[2]),
        .ld_ins4   (ld[3]),
        .play      (play),
        .timing    (timing),
        .trig      (trig),
        .gate      (gate),
        .hits      (hits),
        .step_led  (step_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        play_seen <= play;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [7:0] p);
        pattern_in = p;
        ld[i]      = 1'b1;
        tick(1);
        ld         = '0;
        tb_pat[i]  = p;
    endtask

    // A stable change is accepted 4 edges after it is driven, if play is held high.
    task automatic set_timing(input logic [3:0] v);
        exp_t e;
        timing = v;
        if (play && v != last_t) begin
            e.cyc  = cyc + 4;
            e.trig = '0;
            e.led  = '0;
            if (v >= 4'd1 && v <= 4'd8) begin
                for (int i = 0; i < 4; i++) begin
                    e.trig[i] = tb_pat[i][v-1];
                end
                e.led = 8'd1 << (v - 1);
            end
            e.hits = e.trig;
            sb.push_back(e);
        end
        last_t = v;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int i = 0; i < 4; i++) left[i] = 0;
                exp_led = '0;
            end else begin
                if (!play_seen) begin
                    for (int i = 0; i < 4; i++) left[i] = 0;
                    exp_led = '0;
                end
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    check_eq("missed_entry_cycle", cyc, sb[0].cyc);
                    void'(sb.pop_front());
                end
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    check_eq("entry_trig", trig, e.trig);
                    check_eq("entry_hits", hits, e.hits);
                    exp_led = e.led;
                    for (int i = 0; i < 4; i++) begin
                        if (e.trig[i]) left[i] = G;
                    end
                end else begin
                    check_eq("idle_trig", trig, 0);
                end
                check_eq("step_led", step_led, exp_led);
                for (int i = 0; i < 4; i++) begin
                    check_eq($sformatf("gate%0d", i), gate[i], left[i] != 0);
                    if (left[i] > 0) left[i]--;
                end
            end
        end
    end

    initial begin
        reset      = 1'b0;
        play       = 1'b0;
        timing     = 4'd0;
        pattern_in = 8'd0;
        ld         = '0;
        last_t     = 4'd0;
        exp_led    = '0;
        for (int i = 0; i < 4; i++) begin
            tb_pat[i] = 8'd0;
            left[i]   = 0;
        end
        tick(3);
        check_eq("rst_trig", trig, 0);
        check_eq("rst_gate", gate, 0);
        check_eq("rst_led", step_led, 0);
        reset = 1'b1;

        load(0, 8'h81);
        load(1, 8'h04);
        play = 1'b1;
        tick(2);

        // Basic hits with long spacing
        set_timing(4'd1);
        tick(20);
        set_timing(4'd2);
        tick(20);
        set_timing(4'd3);
        tick(20);

        // Wrap at minimum spacing keeps gate0 continuously high
        load(0, 8'hFF);
        tick(2);
        set_timing(4'd7);
        tick(4);
        set_timing(4'd8);
        tick(4);
        set_timing(4'd1);
        tick(20);

        // One-cycle glitch to 7 must be ignored
        timing = 4'd7;
        tick(1);
        set_timing(4'd2);
        tick(5);

        // Stop mid-gate, then a change while stopped
        play = 1'b0;
        tick(3);
        set_timing(4'd5);
        tick(10);
        play = 1'b1;
        tick(3);
        set_timing(4'd3);
        tick(10);

        // Invalid index
        set_timing(4'd12);
        tick(10);
        check_eq("invalid_hits", hits, 0);

        // Asynchronous reset mid-gate
        set_timing(4'd4);
        tick(5);
        #1;
        reset = 1'b0;
        #1;
        check_eq("async_rst_gate", gate, 0);
        check_eq("async_rst_trig", trig, 0);
        check_eq("async_rst_hits", hits, 0);
        check_eq("async_rst_led", step_led, 0);
        timing = 4'd0;
        play   = 1'b0;
        last_t = 4'd0;
        for (int i = 0; i < 4; i++) tb_pat[i] = 8'd0;
        tick(2);
        reset = 1'b1;

        // After reset only pat1 is reloaded; pat2 must be cleared
        load(0, 8'h81);
        play = 1'b1;
        tick(2);
        set_timing(4'd1);
        tick(8);
        set_timing(4'd3);
        tick(8);
        set_timing(4'd8);
        tick(10);

        check_eq("sb_drained", sb.size(), 0);
        play = 1'b0;
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
